// File: rtl/toy_bus_age_arb_n.sv
// toy_bus_age_arb_n: N-input least-recently-granted (age matrix) arbiter for ToyBusReq with grant locking
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_vld / in_rdy             per-channel request handshake (in_rdy one-hot or zero)
//   in_addr .. in_tgt_id        flattened per-channel payloads, channel k at [k*W +: W]
//   in_lock                     1 = next beat from this channel must follow this one
//   out_vld / out_rdy           merged output handshake
//   out_addr .. out_tgt_id      selected payload
//   out_grant                   one-hot source of the current out_vld beat, zero when idle
module toy_bus_age_arb_n #(
    parameter int N_IN    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int OP_W    = 4,
    parameter int LOCK_EN = 1,
    parameter int OUT_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_IN-1:0]            in_vld,
    output logic [N_IN-1:0]            in_rdy,
    input  logic [N_IN*ADDR_W-1:0]     in_addr,
    input  logic [N_IN*DATA_W/8-1:0]   in_strb,
    input  logic [N_IN*DATA_W-1:0]     in_data,
    input  logic [N_IN*OP_W-1:0]       in_opcode,
    input  logic [N_IN*ID_W-1:0]       in_src_id,
    input  logic [N_IN*ID_W-1:0]       in_tgt_id,
    input  logic [N_IN-1:0]            in_lock,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W/8-1:0]        out_strb,
    output logic [DATA_W-1:0]          out_data,
    output logic [OP_W-1:0]            out_opcode,
    output logic [ID_W-1:0]            out_src_id,
    output logic [ID_W-1:0]            out_tgt_id,
    output logic [N_IN-1:0]            out_grant
);
    localparam int SW = DATA_W / 8;

    // age[i][j] = 1: j is older than i, so i yields to j
    logic [N_IN-1:0] age [N_IN];
    logic [N_IN-1:0] sel, grant, acc, lock_q, lock_nx;
    logic            lock_act, lock_act_nx, seq_q, seq_nx;
    logic            fwd_vld, load, vld_q;
    logic [ADDR_W-1:0] m_addr;
    logic [SW-1:0]     m_strb;
    logic [DATA_W-1:0] m_data;
    logic [OP_W-1:0]   m_opcode;
    logic [ID_W-1:0]   m_src_id, m_tgt_id;

    // diagonal is masked: a channel never yields to itself
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_IN; i++)
            sel[i] = in_vld[i] & ~|(age[i] & in_vld & ~(N_IN'(1) << i));
    end

    assign grant   = lock_act ? lock_q : sel;
    assign load    = (OUT_REG != 0) ? (~vld_q | out_rdy) : out_rdy;
    assign in_rdy  = grant & {N_IN{load}};
    assign acc     = in_vld & in_rdy;
    assign fwd_vld = |(in_vld & grant);

    always_comb begin
        m_addr   = '0;
        m_strb   = '0;
        m_data   = '0;
        m_opcode = '0;
        m_src_id = '0;
        m_tgt_id = '0;
        for (int k = 0; k < N_IN; k++) begin
            m_addr   = m_addr   | ({ADDR_W{grant[k]}} & in_addr[k*ADDR_W +: ADDR_W]);
            m_strb   = m_strb   | ({SW{grant[k]}}     & in_strb[k*SW +: SW]);
            m_data   = m_data   | ({DATA_W{grant[k]}} & in_data[k*DATA_W +: DATA_W]);
            m_opcode = m_opcode | ({OP_W{grant[k]}}   & in_opcode[k*OP_W +: OP_W]);
            m_src_id = m_src_id | ({ID_W{grant[k]}}   & in_src_id[k*ID_W +: ID_W]);
            m_tgt_id = m_tgt_id | ({ID_W{grant[k]}}   & in_tgt_id[k*ID_W +: ID_W]);
        end
    end

    // seq_q separates a sequence lock (survives an idle owner) from a stability
    // lock (dropped as soon as the stalled beat disappears)
    always_comb begin
        lock_act_nx = lock_act;
        lock_nx     = lock_q;
        seq_nx      = seq_q;
        if (|acc) begin
            lock_act_nx = (LOCK_EN != 0) && |(acc & in_lock);
            lock_nx     = acc;
            seq_nx      = lock_act_nx;
        end else if (OUT_REG == 0 && fwd_vld && !out_rdy) begin
            lock_act_nx = 1'b1;
            lock_nx     = grant;
        end else if (lock_act && !seq_q) begin
            lock_act_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_act <= 1'b0;
            lock_q   <= '0;
            seq_q    <= 1'b0;
        end else begin
            lock_act <= lock_act_nx;
            lock_q   <= lock_nx;
            seq_q    <= seq_nx;
        end
    end

    // accepted channel becomes youngest: its row fills, its column clears elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++)
                for (int j = 0; j < N_IN; j++)
                    age[i][j] <= (j < i);
        end else if (|acc) begin
            for (int i = 0; i < N_IN; i++)
                age[i] <= acc[i] ? '1 : (age[i] & ~acc);
        end
    end

    if (OUT_REG != 0) begin : g_reg
        logic [ADDR_W-1:0] q_addr;
        logic [SW-1:0]     q_strb;
        logic [DATA_W-1:0] q_data;
        logic [OP_W-1:0]   q_opcode;
        logic [ID_W-1:0]   q_src_id, q_tgt_id;
        logic [N_IN-1:0]   q_grant;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q    <= 1'b0;
                q_grant  <= '0;
                q_addr   <= '0;
                q_strb   <= '0;
                q_data   <= '0;
                q_opcode <= '0;
                q_src_id <= '0;
                q_tgt_id <= '0;
            end else if (load) begin
                vld_q    <= fwd_vld;
                q_grant  <= in_vld & grant;
                q_addr   <= m_addr;
                q_strb   <= m_strb;
                q_data   <= m_data;
                q_opcode <= m_opcode;
                q_src_id <= m_src_id;
                q_tgt_id <= m_tgt_id;
            end
        end
        assign out_vld    = vld_q;
        assign out_grant  = q_grant;
        assign out_addr   = q_addr;
        assign out_strb   = q_strb;
        assign out_data   = q_data;
        assign out_opcode = q_opcode;
        assign out_src_id = q_src_id;
        assign out_tgt_id = q_tgt_id;
    end else begin : g_comb
        assign vld_q      = 1'b0;
        assign out_vld    = fwd_vld;
        assign out_grant  = in_vld & grant;
        assign out_addr   = m_addr;
        assign out_strb   = m_strb;
        assign out_data   = m_data;
        assign out_opcode = m_opcode;
        assign out_src_id = m_src_id;
        assign out_tgt_id = m_tgt_id;
    end
endmodule

// File: tb/tb_toy_bus_age_arb_n.sv
// tb_toy_bus_age_arb_n: scoreboard bench for toy_bus_age_arb_n in combinational and registered modes
module tb_toy_bus_age_arb_n;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int OW = 4;
    localparam int IW = 4;
    localparam int PW = AW + DW + SW + OW + IW + IW;

    typedef struct packed {
        logic          vld;
        logic [N-1:0]  grant;
        logic [N-1:0]  rdy;
        logic          chk_pay;
        logic [PW-1:0] pay;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    in_vld, in_lock;
    logic [N*AW-1:0] in_addr;
    logic [N*SW-1:0] in_strb;
    logic [N*DW-1:0] in_data;
    logic [N*OW-1:0] in_opcode;
    logic [N*IW-1:0] in_src_id, in_tgt_id;
    logic            out_rdy;

    logic [N-1:0]  c_rdy, r_rdy, c_grant, r_grant;
    logic          c_vld, r_vld;
    logic [AW-1:0] c_addr, r_addr;
    logic [SW-1:0] c_strb, r_strb;
    logic [DW-1:0] c_data, r_data;
    logic [OW-1:0] c_op, r_op;
    logic [IW-1:0] c_src, r_src, c_tgt, r_tgt;

    toy_bus_age_arb_n #(.N_IN(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .OP_W(OW),
                        .LOCK_EN(1), .OUT_REG(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(c_rdy),
        .in_addr(in_addr), .in_strb(in_strb), .in_data(in_data), .in_opcode(in_opcode),
        .in_src_id(in_src_id), .in_tgt_id(in_tgt_id), .in_lock(in_lock),
        .out_vld(c_vld), .out_rdy(out_rdy), .out_addr(c_addr), .out_strb(c_strb),
        .out_data(c_data), .out_opcode(c_op), .out_src_id(c_src), .out_tgt_id(c_tgt),
        .out_grant(c_grant)
    );

    toy_bus_age_arb_n #(.N_IN(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .OP_W(OW),
                        .LOCK_EN(1), .OUT_REG(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(r_rdy),
        .in_addr(in_addr), .in_strb(in_strb), .in_data(in_data), .in_opcode(in_opcode),
        .in_src_id(in_src_id), .in_tgt_id(in_tgt_id), .in_lock(in_lock),
        .out_vld(r_vld), .out_rdy(out_rdy), .out_addr(r_addr), .out_strb(r_strb),
        .out_data(r_data), .out_opcode(r_op), .out_src_id(r_src), .out_tgt_id(r_tgt),
        .out_grant(r_grant)
    );

    int n_chk = 0;
    int n_fail = 0;
    int mode = 0;
    exp_t sb[$];
    logic [N-1:0] obs_g[$];
    int beats_obs = 0;
    int beats_exp = 0;

    logic [N-1:0]  pend, plk;
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_data [N];
    logic [SW-1:0] p_strb [N];
    logic [OW-1:0] p_op   [N];
    logic [IW-1:0] p_tgt  [N];

    // reference model: LRU list (front = oldest) plus lock owner
    int   order[$];
    bit   locked, seq;
    int   lock_ch;
    bit   rv;
    logic [N-1:0]  rg;
    logic [PW-1:0] rp;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pay_of(input int k);
        return {p_addr[k], p_data[k], p_strb[k], p_op[k], IW'(k), p_tgt[k]};
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            in_addr[k*AW +: AW]   = p_addr[k];
            in_data[k*DW +: DW]   = p_data[k];
            in_strb[k*SW +: SW]   = p_strb[k];
            in_opcode[k*OW +: OW] = p_op[k];
            in_src_id[k*IW +: IW] = IW'(k);
            in_tgt_id[k*IW +: IW] = p_tgt[k];
        end
        in_vld  = pend;
        in_lock = plk & pend;
    endtask

    task automatic model_reset();
        order = {0, 1, 2, 3};
        locked = 0;
        seq = 0;
        lock_ch = 0;
        rv = 0;
        rg = '0;
        rp = '0;
    endtask

    task automatic reset_dut();
        exp_t e;
        e = '{vld: 1'b0, grant: '0, rdy: '0, chk_pay: 1'b1, pay: '0};
        rst_n = 1'b0;
        out_rdy = 1'b1;
        pend = '0;
        plk = '0;
        drive();
        model_reset();
        sb.push_back(e);
        @(posedge clk); #1;
        sb.push_back(e);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // one bus cycle: raise new beats, predict visible outputs, advance the model
    task automatic step(input logic [N-1:0] raise, input logic [N-1:0] lk, input logic rdy);
        exp_t e;
        int g;
        bit ov, ld, acc;
        for (int k = 0; k < N; k++)
            if (raise[k] && !pend[k]) begin
                pend[k] = 1'b1;
                plk[k] = lk[k];
                p_addr[k] = $urandom;
                p_data[k] = $urandom;
                p_strb[k] = SW'($urandom);
                p_op[k] = OW'($urandom);
                p_tgt[k] = IW'($urandom);
            end
        out_rdy = rdy;
        drive();
        g = -1;
        if (locked) g = lock_ch;
        else
            for (int i = 0; i < order.size(); i++)
                if (g < 0 && pend[order[i]]) g = order[i];
        ov = (g >= 0) && pend[g];
        if (mode == 0) begin
            e.vld = ov;
            e.grant = ov ? N'(1) << g : '0;
            e.chk_pay = ov;
            e.pay = '0;
            if (ov) e.pay = pay_of(g);
            ld = rdy;
        end else begin
            e.vld = rv;
            e.grant = rg;
            e.chk_pay = rv;
            e.pay = rp;
            ld = !rv || rdy;
        end
        e.rdy = (g >= 0 && ld) ? N'(1) << g : '0;
        acc = ov && ld;
        sb.push_back(e);
        if (mode == 1 && rv && rdy) beats_exp++;
        if (mode == 1 && ld) begin
            rv = acc;
            rg = acc ? N'(1) << g : '0;
            if (acc) rp = pay_of(g);
        end
        if (acc) begin
            for (int i = 0; i < order.size(); i++)
                if (order[i] == g) begin
                    order.delete(i);
                    break;
                end
            order.push_back(g);
            locked = plk[g];
            seq = plk[g];
            lock_ch = g;
            pend[g] = 1'b0;
        end else if (mode == 0 && ov && !rdy) begin
            locked = 1;
            lock_ch = g;
        end else if (locked && !seq) begin
            locked = 0;
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic          a_vld;
            logic [N-1:0]  a_grant, a_rdy;
            logic [PW-1:0] a_pay;
            e = sb.pop_front();
            a_vld   = mode == 1 ? r_vld : c_vld;
            a_grant = mode == 1 ? r_grant : c_grant;
            a_rdy   = mode == 1 ? r_rdy : c_rdy;
            a_pay   = mode == 1 ? {r_addr, r_data, r_strb, r_op, r_src, r_tgt}
                                : {c_addr, c_data, c_strb, c_op, c_src, c_tgt};
            chk("out_vld", PW'(a_vld), PW'(e.vld));
            chk("out_grant", PW'(a_grant), PW'(e.grant));
            chk("in_rdy", PW'(a_rdy), PW'(e.rdy));
            if (e.chk_pay) chk("payload", a_pay, e.pay);
            if (a_vld && out_rdy) begin
                if (mode == 0) obs_g.push_back(a_grant);
                else beats_obs++;
            end
        end
    end

    initial begin
        pend = '0;
        plk = '0;
        out_rdy = 1'b0;
        for (int k = 0; k < N; k++) begin
            p_addr[k] = '0;
            p_data[k] = '0;
            p_strb[k] = '0;
            p_op[k] = '0;
            p_tgt[k] = '0;
        end
        drive();
        model_reset();
        @(posedge clk); #1;

        // reset priority: round robin from channel 0
        mode = 0;
        reset_dut();
        obs_g.delete();
        repeat (8) step(4'b1111, 4'b0000, 1'b1);
        chk("prio_count", PW'(obs_g.size()), PW'(8));
        for (int i = 0; i < 8; i++)
            if (i < obs_g.size()) chk("prio_grant", PW'(obs_g[i]), PW'(N'(1) << (i % 4)));

        // late arrival: ch2 becomes youngest so ch0 wins next
        reset_dut();
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0101, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // stall stability: ch1 held while ch0 arrives
        reset_dut();
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0011, 4'b0000, 1'b0);
        step(4'b0011, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // sequence lock: ch3 beats locked 1,1,0 with idle gaps
        reset_dut();
        step(4'b1000, 4'b1000, 1'b1);
        step(4'b0011, 4'b0000, 1'b1);
        step(4'b0011, 4'b0000, 1'b1);
        step(4'b1011, 4'b1000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b1000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // random traffic, combinational mode
        reset_dut();
        repeat (300) step(N'($urandom), N'($urandom), ($urandom % 4) != 0);

        // reset mid-lock, combinational mode
        reset_dut();
        step(4'b0100, 4'b0100, 1'b1);
        step(4'b0011, 4'b0000, 1'b1);
        reset_dut();
        step(4'b1111, 4'b0000, 1'b1);

        // registered mode: out_rdy pattern 1,0,1,1 on two channels
        mode = 1;
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] pat;
            pat = 4'b1101;
            step(4'b0011, 4'b0000, pat[i % 4]);
        end
        repeat (4) step(4'b0000, 4'b0000, 1'b1);

        // random traffic, registered mode
        reset_dut();
        repeat (300) step(N'($urandom), N'($urandom), ($urandom % 4) != 0);
        repeat (4) step(4'b0000, 4'b0000, 1'b1);
        chk("beat_count", PW'(beats_obs), PW'(beats_exp));

        // reset mid-lock with a registered beat in flight
        reset_dut();
        step(4'b0100, 4'b0100, 1'b1);
        reset_dut();
        step(4'b1111, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        @(posedge clk); #1;
        chk("sb_empty", PW'(sb.size()), PW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/toy_bus_age_arb_n.md
# toy_bus_age_arb_n

Parametrised N-input age-matrix arbiter for ToyBusReq traffic. It merges `N_IN` request channels onto one output using least-recently-granted (age) priority. It adds two things over the fixed 2-input arbiter: grant locking (valid/payload stability plus multi-beat lock sequences) and an optional registered output stage. It sits in the bus network wherever several masters (LSU, debug, DMA, fetch) converge on one target port.

## Interface
- `N_IN`, 4, number of input channels (2..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`
- `ID_W`, 4, src_id/tgt_id width
- `LOCK_EN`, 1, 1 = honour `in_lock` multi-beat locking; 0 = `in_lock` ignored
- `OUT_REG`, 0, 0 = combinational forward path; 1 = one registered output stage
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `in_vld` in `N_IN`: per-channel request valid
- `in_rdy` out `N_IN`: per-channel ready, one-hot or zero
- `in_addr`, `in_strb`, `in_data`, `in_opcode`, `in_src_id`, `in_tgt_id` in `N_IN`×field: flattened payloads, channel k at slice [k*W +: W]
- `in_lock` in `N_IN`: 1 = the next beat from this channel must follow this one
- `out_vld` out 1: merged valid
- `out_rdy` in 1: downstream ready
- `out_addr`/`out_strb`/`out_data`/`out_opcode`/`out_src_id`/`out_tgt_id` out: selected payload
- `out_grant` out `N_IN`: one-hot source of the current `out_vld` beat, zero when idle

## Operation
- **Age matrix.** `age[i][j]` (i≠j) = 1 means j is older than i, so i yields to j.
  - Reset: `age[i][j] = 1` iff j<i, so lower index wins on first contention.
- **Selection.** `sel[i] = in_vld[i] & ~|(age[i] & in_vld)`.
  - `sel` is one-hot whenever any `in_vld` is set, and zero otherwise.
- **Update on accept of channel k** (`in_vld[k] & in_rdy[k]`):
  - row k set to all 1s (k becomes youngest);
  - column k cleared in every other row.
  - At most one update per cycle. Diagonal is don't-care.
- **Grant and lock state.** `grant = lock_act ? lock_q : sel`.
  - `lock_q` (`N_IN` bits) and `lock_act` reset to 0.
- **Stability lock (always on, `OUT_REG=0`).** If `out_vld & ~out_rdy`, then next cycle `lock_act=1` and `lock_q=grant`.
  - It releases on the first accept.
  - An input must not drop `vld` while stalled (bus rule). If it does anyway, `out_vld` falls and the lock clears the following cycle.
- **Sequence lock (`LOCK_EN=1`).**
  - An accepted beat with `in_lock[k]=1` sets `lock_act=1`, `lock_q=onehot(k)`.
  - An accepted beat from k with `in_lock[k]=0` clears `lock_act`.
  - While locked, all other channels see `in_rdy=0` even if k is idle.
- **OUT_REG=0 datapath.**
  - `out_* = OR over k of (in_*[k] & grant[k])`, `out_vld = |(in_vld & grant)`.
  - `in_rdy[k] = grant[k] & out_rdy`.
- **OUT_REG=1 datapath.**
  - Output register `{vld_q, payload_q, grant_q}` loads when `~vld_q | out_rdy`.
  - `in_rdy[k] = grant[k] & (~vld_q | out_rdy)`.
  - Full throughput (one beat per cycle under continuous `out_rdy`). No combinational path from `out_rdy` to `out_vld`/`out_*`.
  - The stability lock is not needed here, because the register holds the payload.
- **Reset values.** `out_vld=0`, `out_grant=0`, `out_*=0` in both modes. The `OUT_REG=0` outputs are 0 because all `in_vld` are low during reset per bus rule.
- **Reset mid-sequence.** Lock, age matrix and output register return to reset values immediately (asynchronous). An in-flight registered beat is dropped.

## Timing
- Latency, `OUT_REG=0`: 0 cycles, `in_vld`→`out_vld` same cycle.
- Latency, `OUT_REG=1`: 1 cycle.
- Age update and lock update both take effect the cycle after the accepting edge.
- Simultaneous accept and sequence-lock release: the lock clears and the age update is applied in the same edge. The next arbitration uses both new states.
- A channel that is granted but not valid produces no update and no accept.

## Test plan
- **Reset priority.** `N_IN=4`, reset, then all four `in_vld=1` and `out_rdy=1` for 8 cycles.
  - Grants are 0,1,2,3,0,1,2,3; each `out_src_id` matches its channel.
- **Late arrival.** Ch2 alone for 1 beat, then ch0 and ch2 both valid.
  - Ch0 is granted first (ch2 is youngest); ch2 follows.
- **Stall stability** (`OUT_REG=0`). Ch1 valid with `out_rdy=0` for 3 cycles; ch0 rises in cycle 2.
  - `out_grant` stays `0010` and `out_addr` is stable until the accept.
  - Ch0 is granted the next cycle.
- **Sequence lock** (`LOCK_EN=1`). Ch3 sends 3 beats with `in_lock` = 1,1,0 while ch0/ch1 are valid throughout; ch3 idles 2 cycles between beats.
  - `in_rdy[0]` and `in_rdy[1]` stay 0 until the third ch3 beat is accepted.
  - Ch0 is granted next.
- **Registered mode** (`OUT_REG=1`). Continuous 2-channel traffic with `out_rdy` pattern 1,0,1,1.
  - `out_vld` lags `in_vld` by 1 cycle.
  - Exactly one beat is accepted per cycle in which `out_rdy=1` and `out_vld=1`; no beat is lost or duplicated (scoreboard).
- **Reset mid-lock.** Assert `rst_n=0` while ch2 holds a sequence lock and `vld_q=1`.
  - `out_vld=0` and `in_rdy=0` immediately.
  - After release, reset priority is restored: ch0 wins.
